// File: rtl/pll_lock_sequencer.sv
// Sequences the TMDS clock PLL: pulses its reset, waits for lock with a timeout, qualifies lock
// over a stability window and only then releases the downstream video reset.
module pll_lock_sequencer #(
  parameter int unsigned RESET_CYCLES  = 16,
  parameter int unsigned LOCK_TIMEOUT  = 27000,
  parameter int unsigned STABLE_CYCLES = 2700,
  parameter int unsigned CNT_W         = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pll_lock,
  input  logic       force_relock,
  output logic       pll_reset,
  output logic       video_reset,
  output logic       ready,
  output logic [7:0] retry_count
);

  typedef enum logic [1:0] {StResetPll, StWaitLock, StStable, StRunning} state_e;

  localparam logic [CNT_W-1:0] ResetLast   = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] StableLast  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntZero     = '0;
  localparam logic [CNT_W-1:0] CntOne      = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       retry_q, retry_d;
  logic             sync_q, lock_s_q;
  logic             pll_reset_q, pll_reset_d;
  logic             video_reset_q, video_reset_d;
  logic             ready_q, ready_d;
  logic             bump;

  // State register, lock synchronizer and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StResetPll;
      cnt_q         <= CntZero;
      retry_q       <= 8'd0;
      sync_q        <= 1'b0;
      lock_s_q      <= 1'b0;
      pll_reset_q   <= 1'b1;
      video_reset_q <= 1'b1;
      ready_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      retry_q       <= retry_d;
      sync_q        <= pll_lock;
      lock_s_q      <= sync_q;
      pll_reset_q   <= pll_reset_d;
      video_reset_q <= video_reset_d;
      ready_q       <= ready_d;
    end
  end

  // Next state; every transition clears the counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bump    = 1'b0;
    if (force_relock) begin
      state_d = StResetPll;
      cnt_d   = CntZero;
    end else begin
      unique case (state_q)
        StResetPll: begin
          if (cnt_q == ResetLast) begin
            state_d = StWaitLock;
            cnt_d   = CntZero;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
        StWaitLock: begin
          if (lock_s_q) begin
            state_d = StStable;
            cnt_d   = CntZero;
          end else if (cnt_q == TimeoutLast) begin
            state_d = StResetPll;
            cnt_d   = CntZero;
            bump    = 1'b1;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
        StStable: begin
          if (!lock_s_q) begin
            state_d = StWaitLock;
            cnt_d   = CntZero;
          end else if (cnt_q == StableLast) begin
            state_d = StRunning;
            cnt_d   = CntZero;
          end else begin
            cnt_d = cnt_q + CntOne;
          end
        end
        StRunning: begin
          if (!lock_s_q) begin
            state_d = StResetPll;
            cnt_d   = CntZero;
            bump    = 1'b1;
          end
        end
        default: begin
          state_d = StResetPll;
          cnt_d   = CntZero;
        end
      endcase
    end
    retry_d = (bump && (retry_q != 8'hFF)) ? retry_q + 8'd1 : retry_q;
  end

  // Outputs decoded from the next state so they update on the same edge as the state register
  always_comb begin
    pll_reset_d   = (state_d == StResetPll);
    video_reset_d = (state_d != StRunning);
    ready_d       = (state_d == StRunning);
  end

  assign pll_reset   = pll_reset_q;
  assign video_reset = video_reset_q;
  assign ready       = ready_q;
  assign retry_count = retry_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scoreboard bench: stimulus pushes expected output snapshots keyed by edge number; the monitor
// checks them and flags any output change that was not announced.
module tb_pll_lock_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       pll_lock;
  logic       force_relock;
  logic       pll_reset;
  logic       video_reset;
  logic       ready;
  logic [7:0] retry_count;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int         c;
    string      name;
    logic       pr;
    logic       vr;
    logic       rdy;
    logic [7:0] rc;
  } exp_t;

  exp_t q[$];

  pll_lock_sequencer #(
    .RESET_CYCLES (4),
    .LOCK_TIMEOUT (20),
    .STABLE_CYCLES(8),
    .CNT_W        (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pll_lock    (pll_lock),
    .force_relock(force_relock),
    .pll_reset   (pll_reset),
    .video_reset (video_reset),
    .ready       (ready),
    .retry_count (retry_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int c, input string name, input logic pr, input logic vr,
                      input logic rdy, input int rc);
    exp_t e;
    e.c    = c;
    e.name = name;
    e.pr   = pr;
    e.vr   = vr;
    e.rdy  = rdy;
    e.rc   = 8'(rc);
    q.push_back(e);
  endtask

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: sample mid-cycle, after the edge numbered cyc
  logic [10:0] last_obs = 'x;
  always @(negedge clk) begin
    logic [10:0] obs;
    exp_t e;
    obs = {pll_reset, video_reset, ready, retry_count};
    if (cyc >= 1) begin
      while (q.size() > 0 && q[0].c < cyc) begin
        e = q.pop_front();
        checks++;
        errors++;
        $display("FAIL %s: expected at edge %0d was never checked (now edge %0d)", e.name, e.c,
                 cyc);
      end
      if (q.size() > 0 && q[0].c == cyc) begin
        e = q.pop_front();
        checks++;
        if (obs !== {e.pr, e.vr, e.rdy, e.rc}) begin
          errors++;
          $display("FAIL %s @edge %0d: got pr=%b vr=%b rdy=%b rc=%0d, want pr=%b vr=%b rdy=%b rc=%0d",
                   e.name, cyc, pll_reset, video_reset, ready, retry_count,
                   e.pr, e.vr, e.rdy, e.rc);
        end
      end else if (obs !== last_obs) begin
        checks++;
        errors++;
        $display("FAIL unexpected_change @edge %0d: got pr=%b vr=%b rdy=%b rc=%0d, want no change",
                 cyc, pll_reset, video_reset, ready, retry_count);
      end
      last_obs = obs;
    end
  end

  initial begin
    int t, f, g, r, r2;
    reset        = 1'b1;
    pll_lock     = 1'b0;
    force_relock = 1'b0;

    // Normal bring-up: reset edges 1..3, pll_reset falls at edge 7, lock sampled at 17
    push(1, "rst_state", 1, 1, 0, 0);
    push(3, "rst_hold", 1, 1, 0, 0);
    push(6, "prst_still_high", 1, 1, 0, 0);
    push(7, "prst_fall", 0, 1, 0, 0);
    push(27, "ready_up", 0, 0, 1, 0);
    goto(3);
    reset = 1'b0;
    goto(16);
    pll_lock = 1'b1;

    // Loss in RUNNING, then a 3-cycle glitch during re-qualification's STABLE
    t = 35;
    push(t + 3, "loss", 1, 1, 0, 1);
    push(t + 7, "loss_prst_fall", 0, 1, 0, 1);
    push(t + 22, "glitch_no_pulse", 0, 1, 0, 1);
    push(t + 33, "requal_ready", 0, 0, 1, 1);
    goto(t);
    pll_lock = 1'b0;
    goto(t + 12);
    pll_lock = 1'b1;
    goto(t + 19);
    pll_lock = 1'b0;
    goto(t + 22);
    pll_lock = 1'b1;

    // force_relock in RUNNING, then again in RESET_PLL to extend the pulse
    f = t + 40;
    push(f + 1, "force_run", 1, 1, 0, 1);
    push(f + 5, "force_extended", 1, 1, 0, 1);
    push(f + 7, "force_prst_fall", 0, 1, 0, 1);
    push(f + 16, "force_ready", 0, 0, 1, 1);
    goto(f);
    force_relock = 1'b1;
    goto(f + 1);
    force_relock = 1'b0;
    goto(f + 2);
    force_relock = 1'b1;
    goto(f + 3);
    force_relock = 1'b0;

    // Five timeouts, then reset together with force_relock mid-WAIT_LOCK
    g = f + 25;
    r = g + 2;
    push(g + 1, "rst2", 1, 1, 0, 0);
    push(r + 4, "rst2_prst_fall", 0, 1, 0, 0);
    for (int k = 1; k <= 5; k++) begin
      push(r + 24 * k, "timeout", 1, 1, 0, k);
      push(r + 24 * k + 4, "timeout_fall", 0, 1, 0, k);
    end
    push(r + 131, "rst_with_force", 1, 1, 0, 0);
    push(r + 132, "rst_with_force_hold", 1, 1, 0, 0);
    goto(g);
    reset    = 1'b1;
    pll_lock = 1'b0;
    goto(r);
    reset = 1'b0;
    goto(r + 130);
    reset        = 1'b1;
    force_relock = 1'b1;
    goto(r + 132);
    reset        = 1'b0;
    force_relock = 1'b0;

    // No lock for 7000 cycles: 24-cycle attempts, retry_count saturates at 255
    r2 = r + 132;
    push(r2 + 4, "nolock_fall", 0, 1, 0, 0);
    for (int k = 1; 24 * k + 4 <= 7000; k++) begin
      push(r2 + 24 * k, "nolock_retry", 1, 1, 0, (k > 255) ? 255 : k);
      push(r2 + 24 * k + 4, "nolock_fall", 0, 1, 0, (k > 255) ? 255 : k);
    end
    push(r2 + 7000, "nolock_end", 0, 1, 0, 255);
    goto(r2 + 7002);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending entries, want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pll_lock_sequencer.md
# pll_lock_sequencer

Sequences the TMDS clock PLL on the 27 MHz board clock. It pulses the PLL reset and waits for lock with a timeout. It qualifies lock over a stability window and only then releases the video/TMDS pipeline reset. Any lock loss or explicit relock request restarts the sequence. It sits between the board reset/clock and the PLL wrapper. Its `pll_reset` drives the PLL `reset`, and its `video_reset` feeds the per-domain reset synchronizers of the pixel and serializer logic.

## Interface

- `RESET_CYCLES`, 16: cycles `pll_reset` is held high per attempt (≥1).
- `LOCK_TIMEOUT`, 27000: cycles to wait for lock after PLL reset release before retrying (≥1; 1 ms at 27 MHz).
- `STABLE_CYCLES`, 2700: consecutive synchronized-lock-high cycles required before release (≥1).
- `CNT_W`, 16: internal counter width; must hold max(RESET_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)−1.

- `clk` in 1: board clock (27 MHz), the single clock of the block.
- `reset` in 1: synchronous, active-high.
- `pll_lock` in 1: PLL `lock`, asynchronous to `clk`.
- `force_relock` in 1: single-cycle request to restart the sequence.
- `pll_reset` out 1: to the PLL `reset` input.
- `video_reset` out 1: downstream reset, high whenever the clocks are not qualified.
- `ready` out 1: clocks qualified; always the inverse of `video_reset`.
- `retry_count` out 8: saturating count of failed attempts and lock losses.

## Operation

- `pll_lock` passes through a 2-flop synchronizer (`lock_s`). The FSM uses only `lock_s`.
- One counter `cnt` (CNT_W bits) is cleared on every state entry.
- States and transitions:
  - RESET_PLL: `pll_reset`=1. `cnt` increments each cycle; at `cnt`==RESET_CYCLES−1 → WAIT_LOCK.
  - WAIT_LOCK: `pll_reset`=0. If `lock_s`=1 → STABLE. Else if `cnt`==LOCK_TIMEOUT−1 → RESET_PLL and `retry_count`+1. Else `cnt`+1.
  - STABLE: if `lock_s`=0 → WAIT_LOCK, with no retry increment and a fresh timeout. Else if `cnt`==STABLE_CYCLES−1 → RUNNING. Else `cnt`+1.
  - RUNNING: `video_reset`=0, `ready`=1. If `lock_s`=0 → RESET_PLL and `retry_count`+1.
- `force_relock`=1 in any state → RESET_PLL on the next edge. No retry increment. It overrides all other transitions, including re-entering RESET_PLL while already in it, which restarts its count.
- `reset` overrides everything, including `force_relock`.
- `retry_count` saturates at 255. It is cleared only by `reset`.
- All outputs are registered and change on the same edge as the state register. There are no combinational paths from inputs to outputs.

## Timing

- Values during and after `reset`: state RESET_PLL, `cnt`=0, synchronizer flops 0, `pll_reset`=1, `video_reset`=1, `ready`=0, `retry_count`=0.
- After `reset` falls, `pll_reset` remains high for exactly RESET_CYCLES cycles, counting from the first non-reset edge.
- Lock acquisition latency: `pll_lock` is first sampled high at edge n. STABLE is entered at edge n+2. `ready` rises at edge n+2+STABLE_CYCLES, provided lock stays high.
- Lock loss latency: `pll_lock` is first sampled low at edge n in RUNNING. At edge n+2, `ready`=0, `video_reset`=1 and `pll_reset`=1.
- Attempt period with no lock: RESET_CYCLES + LOCK_TIMEOUT cycles per `pll_reset` pulse.
- A lock glitch shorter than one clock may be missed. This is acceptable because STABLE qualifies lock before release.

## Test plan

All scenarios use RESET_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8.

- Normal bring-up: `reset` for 3 cycles, then `pll_lock` rises 10 cycles after `pll_reset` falls → `pll_reset` high exactly 4 cycles; `ready` rises exactly 10 edges after lock is first sampled; `retry_count`=0.
- No lock: `pll_lock` held 0 for 7000 cycles → `pll_reset` 4-cycle pulses every 24 cycles; `retry_count` increments per timeout and holds at 255.
- Glitch in STABLE: `pll_lock` drops for 3 cycles at STABLE cycle 4 → no `pll_reset` pulse; `retry_count` unchanged; `ready` rises 10 edges after lock returns.
- Loss in RUNNING: drop `pll_lock` → `ready`=0 and `pll_reset`=1 two edges later; 4-cycle `pll_reset` pulse; `retry_count`=1; re-qualification follows the bring-up timing.
- `force_relock` pulse in RUNNING → RESET_PLL next edge; `retry_count` unchanged. A second pulse during RESET_PLL extends `pll_reset` to 4 cycles after that pulse.
- `reset` asserted mid-WAIT_LOCK, together with `force_relock`, while `retry_count`=5 → all outputs return to their reset values; `retry_count`=0.
